// File: rtl/gpio_reg_core.sv
// GPIO register file and edge-triggered interrupt engine behind the APB slave.
// Pad inputs pass through a two-flop synchronizer before edge detection.
module gpio_reg_core #(
    parameter int GPIO_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              gpio_we,
    input  logic [31:0]       gpio_addr,
    input  logic [31:0]       gpio_dat_i,
    output logic [31:0]       gpio_dat_o,
    output logic              gpio_inta_o,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe
);

    typedef enum logic [2:0] {
        SEL_IN    = 3'd0,
        SEL_OUT   = 3'd1,
        SEL_OE    = 3'd2,
        SEL_INTE  = 3'd3,
        SEL_PTRIG = 3'd4,
        SEL_INTS  = 3'd5,
        SEL_CTRL  = 3'd6,
        SEL_RSVD  = 3'd7
    } reg_sel_e;

    reg_sel_e          sel;
    logic [GPIO_W-1:0] dat_w;
    logic [GPIO_W-1:0] in_s1, in_s2, in_prev;
    logic [GPIO_W-1:0] r_out, r_oe, r_inte, r_ptrig, r_ints;
    logic              r_ctrl;
    logic              r_inta;
    logic [GPIO_W-1:0] rise, fall, evt, ints_clr;
    logic              unused_bits;

    assign sel   = reg_sel_e'(gpio_addr[4:2]);
    assign dat_w = gpio_dat_i[GPIO_W-1:0];

    // Only the word index is decoded; the remaining address bits alias.
    assign unused_bits = ^{gpio_addr[31:5], gpio_addr[1:0], gpio_dat_i};

    assign rise     = in_s2 & ~in_prev;
    assign fall     = ~in_s2 & in_prev;
    assign evt      = r_inte & ((r_ptrig & rise) | (~r_ptrig & fall));
    assign ints_clr = (gpio_we && sel == SEL_INTS) ? dat_w : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its sources, regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            in_s1   <= '0;
            in_s2   <= '0;
            in_prev <= '0;
        end else begin
            in_s1   <= gpio_in;
            in_s2   <= in_s1;
            in_prev <= in_s2;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_out   <= '0;
            r_oe    <= '0;
            r_inte  <= '0;
            r_ptrig <= '0;
            r_ints  <= '0;
            r_ctrl  <= 1'b0;
            r_inta  <= 1'b0;
        end else begin
            if (gpio_we) begin
                case (sel)
                    SEL_OUT:   r_out   <= dat_w;
                    SEL_OE:    r_oe    <= dat_w;
                    SEL_INTE:  r_inte  <= dat_w;
                    SEL_PTRIG: r_ptrig <= dat_w;
                    SEL_CTRL:  r_ctrl  <= gpio_dat_i[0];
                    default:   ;
                endcase
            end
            // A fresh event outranks a same-cycle W1C of the same bit.
            r_ints <= (r_ints & ~ints_clr) | evt;
            r_inta <= r_ctrl & (|r_ints);
        end
    end

    // NOTE: the read mux assigns a default before the case so no latch is
    // inferred for offsets that are not listed.
    always_comb begin
        gpio_dat_o = 32'd0;
        case (sel)
            SEL_IN:    gpio_dat_o = 32'(in_s2);
            SEL_OUT:   gpio_dat_o = 32'(r_out);
            SEL_OE:    gpio_dat_o = 32'(r_oe);
            SEL_INTE:  gpio_dat_o = 32'(r_inte);
            SEL_PTRIG: gpio_dat_o = 32'(r_ptrig);
            SEL_INTS:  gpio_dat_o = 32'(r_ints);
            SEL_CTRL:  gpio_dat_o = {31'd0, r_ctrl};
            default:   gpio_dat_o = 32'd0;
        endcase
    end

    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign gpio_inta_o = r_inta;

endmodule

// File: tb/tb_gpio_reg_core.sv
// Directed bench for gpio_reg_core: expected values are queued as stimulus is
// applied and popped against the DUT outputs as they become observable.
module tb_gpio_reg_core;

    localparam int GPIO_W = 32;

    localparam logic [31:0] A_IN    = 32'h00;
    localparam logic [31:0] A_OUT   = 32'h04;
    localparam logic [31:0] A_OE    = 32'h08;
    localparam logic [31:0] A_INTE  = 32'h0C;
    localparam logic [31:0] A_PTRIG = 32'h10;
    localparam logic [31:0] A_INTS  = 32'h14;
    localparam logic [31:0] A_CTRL  = 32'h18;
    localparam logic [31:0] A_RSVD  = 32'h1C;

    logic              PCLK;
    logic              PRESETn;
    logic              gpio_we;
    logic [31:0]       gpio_addr;
    logic [31:0]       gpio_dat_i;
    logic [31:0]       gpio_dat_o;
    logic              gpio_inta_o;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_oe;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    gpio_reg_core #(.GPIO_W(GPIO_W)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .gpio_we     (gpio_we),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .gpio_dat_o  (gpio_dat_o),
        .gpio_inta_o (gpio_inta_o),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        gpio_addr  = addr;
        gpio_dat_i = data;
        gpio_we    = 1'b1;
        tick();
        gpio_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        gpio_addr = addr;
        #1;
        compare(gpio_dat_o);
    endtask

    task automatic chk_inta();
        compare({31'd0, gpio_inta_o});
    endtask

    initial begin
        PRESETn    = 1'b0;
        gpio_we    = 1'b0;
        gpio_addr  = '0;
        gpio_dat_i = '0;
        gpio_in    = '0;
        ticks(2);
        PRESETn = 1'b1;
        tick();

        // Reset: get outputs and interrupt active, then reset in mid-write.
        write(A_OUT, 32'hFFFF_FFFF);
        write(A_OE, 32'hFFFF_FFFF);
        write(A_INTE, 32'h1);
        write(A_PTRIG, 32'h1);
        write(A_CTRL, 32'h1);
        expect_val("pre_reset_inta", 32'h1);
        gpio_in = 32'h1;
        ticks(4);
        chk_inta();

        gpio_addr  = A_OUT;
        gpio_dat_i = 32'h1234_5678;
        gpio_we    = 1'b1;
        #1;
        PRESETn = 1'b0;
        gpio_in = '0;
        #1;
        expect_val("rst_gpio_out", 32'h0);
        expect_val("rst_gpio_oe", 32'h0);
        expect_val("rst_inta", 32'h0);
        compare(gpio_out);
        compare(gpio_oe);
        chk_inta();
        expect_val("rst_rd_in", 32'h0);
        expect_val("rst_rd_out", 32'h0);
        expect_val("rst_rd_oe", 32'h0);
        expect_val("rst_rd_inte", 32'h0);
        expect_val("rst_rd_ptrig", 32'h0);
        expect_val("rst_rd_ints", 32'h0);
        expect_val("rst_rd_ctrl", 32'h0);
        expect_val("rst_rd_rsvd", 32'h0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        gpio_we = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();

        // RW registers, reserved and read-only offsets.
        expect_val("out_port", 32'hA5A5_5A5A);
        expect_val("oe_port", 32'hFFFF_0000);
        write(A_OUT, 32'hA5A5_5A5A);
        write(A_OE, 32'hFFFF_0000);
        compare(gpio_out);
        compare(gpio_oe);
        expect_val("out_readback", 32'hA5A5_5A5A);
        expect_val("oe_readback", 32'hFFFF_0000);
        rd(A_OUT);
        rd(A_OE);
        expect_val("rsvd_read", 32'h0);
        expect_val("out_after_rsvd", 32'hA5A5_5A5A);
        write(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD);
        rd(A_OUT);
        expect_val("in_after_ro_write", 32'h0);
        write(A_IN, 32'hFFFF_FFFF);
        rd(A_IN);
        expect_val("ctrl_bit0_only", 32'h1);
        write(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL);
        write(A_CTRL, 32'h0);

        // Input synchronizer: two edges of latency.
        expect_val("in_sync_edge1", 32'h0);
        expect_val("in_sync_edge2", 32'h81);
        gpio_in = 32'h81;
        tick();
        rd(A_IN);
        tick();
        rd(A_IN);

        // Rising-edge interrupt on bit 3.
        write(A_INTE, 32'h8);
        write(A_PTRIG, 32'h8);
        write(A_CTRL, 32'h1);
        expect_val("rise_ints_e2", 32'h0);
        expect_val("rise_ints_e3", 32'h8);
        expect_val("rise_inta_e3", 32'h0);
        expect_val("rise_inta_e4", 32'h1);
        gpio_in = 32'h89;
        ticks(2);
        rd(A_INTS);
        tick();
        rd(A_INTS);
        chk_inta();
        tick();
        chk_inta();
        expect_val("w1c_ints", 32'h0);
        expect_val("w1c_inta_lag", 32'h1);
        expect_val("w1c_inta_clear", 32'h0);
        write(A_INTS, 32'h8);
        rd(A_INTS);
        chk_inta();
        tick();
        chk_inta();

        // Falling edge on bit 0 with the global enable off.
        write(A_CTRL, 32'h0);
        write(A_INTE, 32'h1);
        write(A_PTRIG, 32'h0);
        expect_val("fall_ints", 32'h1);
        expect_val("fall_inta_masked", 32'h0);
        gpio_in = 32'h88;
        ticks(3);
        rd(A_INTS);
        tick();
        chk_inta();
        expect_val("ints_kept_after_inte_clr", 32'h1);
        write(A_INTE, 32'h0);
        rd(A_INTS);
        expect_val("unmask_inta_lag", 32'h0);
        expect_val("unmask_inta", 32'h1);
        write(A_CTRL, 32'h1);
        chk_inta();
        tick();
        chk_inta();
        expect_val("fall_cleanup_inta", 32'h0);
        write(A_INTS, 32'h1);
        tick();
        chk_inta();

        // Same-cycle W1C and new event on bit 3: the event wins.
        write(A_INTE, 32'h8);
        write(A_PTRIG, 32'h8);
        gpio_in = 32'h80;
        ticks(3);
        expect_val("sim_first_ints", 32'h8);
        expect_val("sim_first_inta", 32'h1);
        gpio_in = 32'h88;
        ticks(4);
        rd(A_INTS);
        chk_inta();
        gpio_in = 32'h80;
        ticks(3);
        expect_val("sim_ints_kept", 32'h8);
        expect_val("sim_inta_kept", 32'h1);
        expect_val("sim_ints_next", 32'h8);
        expect_val("sim_inta_next", 32'h1);
        gpio_in = 32'h88;
        ticks(2);
        write(A_INTS, 32'h8);
        rd(A_INTS);
        chk_inta();
        tick();
        rd(A_INTS);
        chk_inta();

        // Multi-cycle W1C strobe leaves other bits and registers untouched.
        write(A_INTE, 32'h9);
        gpio_in = 32'h89;
        ticks(3);
        expect_val("strobe_pre_ints", 32'h9);
        gpio_in = 32'h88;
        ticks(3);
        rd(A_INTS);
        expect_val("strobe_ints", 32'h1);
        expect_val("strobe_inta", 32'h1);
        expect_val("strobe_out_kept", 32'hA5A5_5A5A);
        gpio_addr  = A_INTS;
        gpio_dat_i = 32'h8;
        gpio_we    = 1'b1;
        ticks(2);
        gpio_we = 1'b0;
        rd(A_INTS);
        chk_inta();
        rd(A_OUT);
        expect_val("strobe_ints_later", 32'h1);
        tick();
        rd(A_INTS);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_reg_core.md
Name: gpio_reg_core

Overview:
GPIO register file and interrupt engine that sits directly downstream of the APB slave interface.
- Consumes the slave's register-access strobes (gpio_we, gpio_addr, gpio_dat_i) and returns read data on gpio_dat_o.
- Drives pad-side output/enable vectors and samples pad inputs through a synchronizer.
- Detects programmable edges on inputs, latches them in a sticky status register, and raises gpio_inta_o.

Parameters:
GPIO_W, 32, number of GPIO lines (1..32); register bits above GPIO_W-1 read 0 and ignore writes

Ports:
PCLK  input  1  system clock, all flops on rising edge
PRESETn  input  1  asynchronous active-low reset
gpio_we  input  1  write strobe; level, may stay high several consecutive cycles for one APB access
gpio_addr  input  32  byte address; only [4:2] decoded, [1:0] and [31:5] ignored (aliasing accepted)
gpio_dat_i  input  32  write data
gpio_dat_o  output  32  read data, combinational from gpio_addr and register state
gpio_inta_o  output  1  registered interrupt request, active high
gpio_in  input  GPIO_W  asynchronous pad inputs
gpio_out  output  GPIO_W  pad output values (RGPIO_OUT)
gpio_oe  output  GPIO_W  pad output enables, 1 = drive (RGPIO_OE)

Behaviour:
- Register map (offset, access, reset):
  - 0x00 IN, RO, sync'd input
  - 0x04 OUT, RW, 0
  - 0x08 OE, RW, 0
  - 0x0C INTE, RW, 0 (per-bit enable)
  - 0x10 PTRIG, RW, 0 (1 = rising edge, 0 = falling edge)
  - 0x14 INTS, R/W1C, 0
  - 0x18 CTRL, RW, 0; bit0 = global INTE, other bits read 0
  - 0x1C reserved: reads 0, writes ignored
- Writes take effect at the PCLK edge where gpio_we=1.
- Repeated gpio_we cycles rewrite the same value. All writes, including W1C, are idempotent, so a multi-cycle strobe is harmless.
- gpio_dat_o has no pipeline delay: same-cycle combinational decode, which the slave's access-phase read requires.
- Input path:
  - in_s1 <= gpio_in; in_s2 <= in_s1; in_prev <= in_s2.
  - IN register = in_s2.
  - rise = in_s2 & ~in_prev; fall = ~in_s2 & in_prev.
  - evt[i] = INTE[i] & (PTRIG[i] ? rise[i] : fall[i]).
- INTS update per bit each edge: INTS <= (INTS & ~(we_ints ? gpio_dat_i : 0)) | evt.
  - A new event in the same cycle as a W1C of that bit wins: bit stays 1.
- gpio_inta_o <= CTRL[0] & |INTS. Registered, so it follows INTS by one edge.
- Clearing INTE does not clear already-latched INTS bits.
- Clearing CTRL[0] masks gpio_inta_o but INTS keeps accumulating.
- Latency: a gpio_in change stable before edge 1 gives:
  - IN updated after edge 2.
  - INTS set at edge 3.
  - gpio_inta_o high after edge 4.
- Pulses shorter than one PCLK period may be missed; this is not required to be detected.
- Reset (PRESETn low, asynchronous assert, at any point including mid-access):
  - All registers, synchronizer and in_prev flops go to 0.
  - gpio_out, gpio_oe and gpio_inta_o go to 0 immediately.
  - gpio_dat_o reflects the reset state.
- After reset release, an input held high reads as a rising edge when it reaches in_s2 (in_prev=0). It sets INTS only if INTE/PTRIG were programmed before it arrives.
- No FSM beyond the pipeline registers; writes to the RO/reserved offsets have no side effects.

Test Plan:
- Reset: drive PRESETn=0 mid-write with gpio_we=1 -> gpio_out=0, gpio_oe=0, gpio_inta_o=0; all offsets read 0 except IN=in_s2=0.
- RW registers: write 0xA5A5_5A5A to OUT, 0xFFFF_0000 to OE -> gpio_out=0xA5A5_5A5A and gpio_oe=0xFFFF_0000 the cycle after the write; readback matches; write to 0x1C then read -> 0.
- Input sync: gpio_in 0 -> 0x0000_0081 -> read IN is 0 after 1 edge and 0x81 after 2 edges.
- Rising interrupt, bit 3:
  - Setup: INTE=0x8, PTRIG=0x8, CTRL=1.
  - Stimulus: gpio_in[3] 0->1.
  - Response: INTS=0x8 at edge 3, gpio_inta_o=1 at edge 4.
  - Write INTS=0x8 -> INTS=0, gpio_inta_o=0 one edge later.
- Falling edge and masking: INTE=0x1, PTRIG=0, CTRL=0; gpio_in[0] 1->0 -> INTS=0x1, gpio_inta_o stays 0; then write CTRL=1 -> gpio_inta_o=1 the next edge.
- Simultaneous set/clear: a W1C of INTS bit 3 lands in the same cycle as a new rising event on bit 3 -> INTS[3] stays 1 and gpio_inta_o stays 1.
- Multi-cycle strobe: hold gpio_we=1 for 2 cycles writing INTS=0x8 -> cleared once, with no side effect on other bits.
